// File: rtl/alu_control_mdu.sv
// EX-stage ALU control decoder with an iterative unsigned multiply/divide unit.
// It holds the HI/LO registers and stalls the pipeline while an operation runs.
module alu_control_mdu #(
  parameter int DATA_WIDTH  = 32,
  parameter int ALUOP_WIDTH = 3,
  parameter int OP_WIDTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ALUOP_WIDTH-1:0] ALUOp,
  input  logic [5:0]             ALUFunction,
  input  logic                   instr_valid,
  input  logic [DATA_WIDTH-1:0]  operand_a,
  input  logic [DATA_WIDTH-1:0]  operand_b,
  output logic [OP_WIDTH-1:0]    ALUOperation,
  output logic                   stall,
  output logic                   md_done,
  output logic                   div_by_zero,
  output logic [DATA_WIDTH-1:0]  hi,
  output logic [DATA_WIDTH-1:0]  lo,
  output logic                   sel_hi,
  output logic                   sel_lo
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [ALUOP_WIDTH-1:0] OP_R    = ALUOP_WIDTH'(7);
  localparam logic [ALUOP_WIDTH-1:0] OP_LUI  = ALUOP_WIDTH'(0);
  localparam logic [ALUOP_WIDTH-1:0] OP_ADDI = ALUOP_WIDTH'(4);
  localparam logic [ALUOP_WIDTH-1:0] OP_ORI  = ALUOP_WIDTH'(5);
  localparam logic [ALUOP_WIDTH-1:0] OP_ANDI = ALUOP_WIDTH'(6);

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    acc_hi, acc_lo, divr;
  logic [W-1:0]    step_hi, step_lo;
  logic [W:0]      msum, rsh, rdiff;
  logic [CW-1:0]   cnt;
  logic            rtype, is_multu, is_divu, mdu_req, last;

  assign rtype    = (ALUOp == OP_R);
  assign is_multu = rtype && (ALUFunction == F_MULTU);
  assign is_divu  = rtype && (ALUFunction == F_DIVU);
  assign mdu_req  = instr_valid && (is_multu || is_divu);
  assign sel_hi   = rtype && (ALUFunction == F_MFHI);
  assign sel_lo   = rtype && (ALUFunction == F_MFLO);
  assign last     = (cnt == CW'(W - 1));

  always_comb begin
    ALUOperation = OP_WIDTH'(4'b1001);
    casex ({ALUOp, ALUFunction})
      {OP_R, 6'b100100}:    ALUOperation = OP_WIDTH'(4'b0000);
      {OP_R, 6'b100101}:    ALUOperation = OP_WIDTH'(4'b0001);
      {OP_R, 6'b100111}:    ALUOperation = OP_WIDTH'(4'b0010);
      {OP_R, 6'b100000}:    ALUOperation = OP_WIDTH'(4'b0011);
      {OP_R, 6'b000000}:    ALUOperation = OP_WIDTH'(4'b0101);
      {OP_R, 6'b000010}:    ALUOperation = OP_WIDTH'(4'b0110);
      {OP_R, F_MULTU},
      {OP_R, F_DIVU},
      {OP_R, F_MFHI},
      {OP_R, F_MFLO}:       ALUOperation = OP_WIDTH'(4'b0011);
      {OP_LUI,  6'bxxxxxx}: ALUOperation = OP_WIDTH'(4'b0101);
      {OP_ADDI, 6'bxxxxxx}: ALUOperation = OP_WIDTH'(4'b0011);
      {OP_ORI,  6'bxxxxxx}: ALUOperation = OP_WIDTH'(4'b0001);
      {OP_ANDI, 6'bxxxxxx}: ALUOperation = OP_WIDTH'(4'b0000);
      default:              ALUOperation = OP_WIDTH'(4'b1001);
    endcase
  end

  // One iteration: MUL adds the multiplicand on the low multiplier bit and
  // shifts the product right; DIV shifts the remainder left and subtracts if it fits.
  always_comb begin
    msum    = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? divr : {W{1'b0}})};
    rsh     = {acc_hi, acc_lo[W-1]};
    rdiff   = rsh - {1'b0, divr};
    step_hi = acc_hi;
    step_lo = acc_lo;
    if (state == MUL) begin
      step_hi = msum[W:1];
      step_lo = {msum[0], acc_lo[W-1:1]};
    end else if (rdiff[W]) begin
      step_hi = rsh[W-1:0];
      step_lo = {acc_lo[W-2:0], 1'b0};
    end else begin
      step_hi = rdiff[W-1:0];
      step_lo = {acc_lo[W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = mdu_req;
        if (mdu_req) begin
          if (is_multu)                 state_nxt = MUL;
          else if (operand_b == '0)     state_nxt = DONE;
          else                          state_nxt = DIV;
        end
      end
      MUL, DIV: begin
        stall = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Final iteration writes HI/LO directly, so they are valid throughout DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_hi      <= '0;
      acc_lo      <= '0;
      divr        <= '0;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      md_done     <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      md_done     <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: if (mdu_req) begin
          acc_hi <= '0;
          acc_lo <= is_multu ? operand_b : operand_a;
          divr   <= is_multu ? operand_a : operand_b;
          cnt    <= '0;
          if (is_divu && operand_b == '0) begin
            hi          <= operand_a;
            lo          <= '1;
            md_done     <= 1'b1;
            div_by_zero <= 1'b1;
          end
        end
        MUL, DIV: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
          if (last) begin
            hi      <= step_hi;
            lo      <= step_lo;
            md_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_control_mdu.sv
// Directed bench for alu_control_mdu: decode table, MULTU/DIVU latency and results,
// zero divide, mid-operation reset and back-to-back operations.
module tb_alu_control_mdu;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    ALUOp;
  logic [5:0]    ALUFunction;
  logic          instr_valid;
  logic [W-1:0]  operand_a, operand_b;
  logic [3:0]    ALUOperation;
  logic          stall, md_done, div_by_zero, sel_hi, sel_lo;
  logic [W-1:0]  hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  alu_control_mdu #(.DATA_WIDTH(W), .ALUOP_WIDTH(3), .OP_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .ALUOp(ALUOp), .ALUFunction(ALUFunction),
    .instr_valid(instr_valid), .operand_a(operand_a), .operand_b(operand_b),
    .ALUOperation(ALUOperation), .stall(stall), .md_done(md_done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo), .sel_hi(sel_hi), .sel_lo(sel_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive an MDU request; called just after a rising edge while the unit is idle.
  task automatic start_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    ALUOp = 3'b111; ALUFunction = f; instr_valid = 1'b1;
    operand_a = a; operand_b = b;
  endtask

  // Cycle 0 is the request cycle. Checks latency, stall coverage, HI/LO hold
  // before completion, and the results in the md_done cycle.
  task automatic wait_done(input string tag, input int lat,
                           input logic [W-1:0] pre_hi, input logic [W-1:0] pre_lo,
                           input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                           input logic exp_dz);
    int c = 0;
    int stalls = 0;
    bit held = 1'b1;
    bit seen = 1'b0;
    while (c < 100) begin
      @(negedge clk);
      if (md_done) begin seen = 1'b1; break; end
      if (stall) stalls++;
      if (hi !== pre_hi || lo !== pre_lo) held = 1'b0;
      @(posedge clk); #1;
      if (c == 0) instr_valid = 1'b0;
      c++;
    end
    chk({tag, " done_seen"}, 64'(seen), 64'd1);
    chk({tag, " latency"},   64'(c), 64'(lat));
    chk({tag, " stall_cyc"}, 64'(stalls), 64'(lat));
    chk({tag, " hilo_held"}, 64'(held), 64'd1);
    chk({tag, " hi"},        64'(hi), 64'(exp_hi));
    chk({tag, " lo"},        64'(lo), 64'(exp_lo));
    chk({tag, " dz"},        64'(div_by_zero), 64'(exp_dz));
    chk({tag, " stall_done"}, 64'(stall), 64'd0);
  endtask

  typedef struct { logic [2:0] op; logic [5:0] fn; logic [3:0] exp; } dec_t;
  dec_t dec_tab[15] = '{
    '{3'b111, 6'b100100, 4'b0000}, '{3'b111, 6'b100101, 4'b0001},
    '{3'b111, 6'b100111, 4'b0010}, '{3'b111, 6'b100000, 4'b0011},
    '{3'b111, 6'b000000, 4'b0101}, '{3'b111, 6'b000010, 4'b0110},
    '{3'b111, 6'b011001, 4'b0011}, '{3'b111, 6'b011011, 4'b0011},
    '{3'b111, 6'b010000, 4'b0011}, '{3'b111, 6'b010010, 4'b0011},
    '{3'b000, 6'b101010, 4'b0101}, '{3'b100, 6'b000000, 4'b0011},
    '{3'b101, 6'b111111, 4'b0001}, '{3'b110, 6'b010000, 4'b0000},
    '{3'b111, 6'b101010, 4'b1001}
  };

  initial begin
    reset = 1'b0; ALUOp = 3'b011; ALUFunction = 6'b0; instr_valid = 1'b0;
    operand_a = '0; operand_b = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst stall", 64'(stall), 64'd0);
    chk("rst md_done", 64'(md_done), 64'd0);
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    chk("dec aluop011", 64'(ALUOperation), 64'h9);

    foreach (dec_tab[i]) begin
      ALUOp = dec_tab[i].op; ALUFunction = dec_tab[i].fn;
      #1;
      chk($sformatf("dec %b_%b", dec_tab[i].op, dec_tab[i].fn), 64'(ALUOperation), 64'(dec_tab[i].exp));
    end
    ALUOp = 3'b111; ALUFunction = 6'b010000; #1;
    chk("mfhi sel_hi", 64'(sel_hi), 64'd1);
    chk("mfhi sel_lo", 64'(sel_lo), 64'd0);
    ALUFunction = 6'b010010; #1;
    chk("mflo sel_hi", 64'(sel_hi), 64'd0);
    chk("mflo sel_lo", 64'(sel_lo), 64'd1);
    chk("mflo no_stall", 64'(stall), 64'd0);

    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    start_op(6'b011001, 32'd7, 32'd6);
    wait_done("mul7x6", 33, 32'd0, 32'd0, 32'd0, 32'd42, 1'b0);
    @(posedge clk); #1;

    start_op(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("mulmax", 33, 32'd0, 32'd42, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    @(posedge clk); #1;

    start_op(6'b011011, 32'd100, 32'd7);
    wait_done("div100_7", 33, 32'hFFFFFFFE, 32'h1, 32'd2, 32'd14, 1'b0);
    @(posedge clk); #1;

    start_op(6'b011011, 32'd5, 32'd0);
    wait_done("div5_0", 1, 32'd2, 32'd14, 32'd5, 32'hFFFFFFFF, 1'b0 | 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("dz pulse_end", 64'(div_by_zero), 64'd0);
    @(posedge clk); #1;

    // Reset during the 10th cycle of a MULTU
    start_op(6'b011001, 32'd123, 32'd456);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort stall", 64'(stall), 64'd0);
    chk("abort md_done", 64'(md_done), 64'd0);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    begin
      bit any_done = 1'b0;
      repeat (30) begin
        @(negedge clk);
        if (md_done) any_done = 1'b1;
      end
      chk("abort no_done", 64'(any_done), 64'd0);
    end
    @(posedge clk); #1;
    start_op(6'b011011, 32'd9, 32'd3);
    wait_done("div9_3", 33, 32'd0, 32'd0, 32'd0, 32'd3, 1'b0);

    // Back-to-back: second request offered in the cycle right after DONE
    @(posedge clk); #1;
    start_op(6'b011001, 32'd3, 32'd5);
    wait_done("b2b mul", 33, 32'd0, 32'd3, 32'd0, 32'd15, 1'b0);
    @(posedge clk); #1;
    start_op(6'b011011, 32'd100, 32'd9);
    wait_done("b2b div", 33, 32'd0, 32'd15, 32'd1, 32'd11, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b idle_stall", 64'(stall), 64'd0);
    chk("b2b hold_lo", 64'(lo), 64'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
